// File: rtl/enigma_core.sv
// Three-rotor Enigma I engine (rotors I-II-III, reflector B, rings AAA, no plugboard).
// Stage 1 captures the symbol with its stepped rotor positions; stage 2 registers the cipher letter.
module enigma_core #(
    parameter int unsigned INIT_L = 0,
    parameter int unsigned INIT_M = 0,
    parameter int unsigned INIT_R = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] symb_i,
    input  logic       symb_val_i,
    input  logic       load_i,
    input  logic [4:0] pos_l_i,
    input  logic [4:0] pos_m_i,
    input  logic [4:0] pos_r_i,
    output logic [6:0] encod_o,
    output logic       encod_val_o,
    output logic       err_o,
    output logic [4:0] pos_l_o,
    output logic [4:0] pos_m_o,
    output logic [4:0] pos_r_o
);

    localparam logic [4:0] INIT_L_C = 5'(INIT_L);
    localparam logic [4:0] INIT_M_C = 5'(INIT_M);
    localparam logic [4:0] INIT_R_C = 5'(INIT_R);

    localparam logic [4:0] NOTCH_R = 5'd21;
    localparam logic [4:0] NOTCH_M = 5'd4;

    typedef enum logic [2:0] {
        TBL_I_F,
        TBL_II_F,
        TBL_III_F,
        TBL_I_B,
        TBL_II_B,
        TBL_III_B
    } tbl_e;

    localparam logic [4:0] ROT_I_F [0:25] = '{
        5'd4,  5'd10, 5'd12, 5'd5,  5'd11, 5'd6,  5'd3,  5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
        5'd22, 5'd24, 5'd7,  5'd23, 5'd20, 5'd18, 5'd15, 5'd0,  5'd8,  5'd1,  5'd17, 5'd2,  5'd9};
    localparam logic [4:0] ROT_II_F [0:25] = '{
        5'd0,  5'd9,  5'd3,  5'd10, 5'd18, 5'd8,  5'd17, 5'd20, 5'd23, 5'd1,  5'd11, 5'd7,  5'd22,
        5'd19, 5'd12, 5'd2,  5'd16, 5'd6,  5'd25, 5'd13, 5'd15, 5'd24, 5'd5,  5'd21, 5'd14, 5'd4};
    localparam logic [4:0] ROT_III_F [0:25] = '{
        5'd1,  5'd3,  5'd5,  5'd7,  5'd9,  5'd11, 5'd2,  5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
        5'd13, 5'd24, 5'd4,  5'd8,  5'd22, 5'd6,  5'd0,  5'd10, 5'd12, 5'd14, 5'd20, 5'd18, 5'd16};
    localparam logic [4:0] ROT_I_B [0:25] = '{
        5'd20, 5'd22, 5'd24, 5'd6,  5'd0,  5'd3,  5'd5,  5'd15, 5'd21, 5'd25, 5'd1,  5'd4,  5'd2,
        5'd10, 5'd12, 5'd19, 5'd7,  5'd23, 5'd18, 5'd11, 5'd17, 5'd8,  5'd13, 5'd16, 5'd14, 5'd9};
    localparam logic [4:0] ROT_II_B [0:25] = '{
        5'd0,  5'd9,  5'd15, 5'd2,  5'd25, 5'd22, 5'd17, 5'd11, 5'd5,  5'd1,  5'd3,  5'd10, 5'd14,
        5'd19, 5'd24, 5'd20, 5'd16, 5'd6,  5'd4,  5'd13, 5'd7,  5'd23, 5'd12, 5'd8,  5'd21, 5'd18};
    localparam logic [4:0] ROT_III_B [0:25] = '{
        5'd19, 5'd0,  5'd6,  5'd1,  5'd15, 5'd2,  5'd18, 5'd3,  5'd16, 5'd4,  5'd20, 5'd5,  5'd21,
        5'd13, 5'd22, 5'd7,  5'd25, 5'd8,  5'd24, 5'd9,  5'd23, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12};
    // Reflector B is an involution with no fixed points, so no letter ever encodes to itself.
    localparam logic [4:0] REFL_B [0:25] = '{
        5'd24, 5'd17, 5'd20, 5'd7,  5'd16, 5'd18, 5'd11, 5'd3,  5'd15, 5'd23, 5'd13, 5'd6,  5'd14,
        5'd10, 5'd12, 5'd8,  5'd4,  5'd1,  5'd5,  5'd25, 5'd2,  5'd22, 5'd21, 5'd9,  5'd0,  5'd19};

    function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'd26) s = s - 6'd26;
        return s[4:0];
    endfunction

    function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
        logic signed [5:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        if (d < 0) d = d + 6'sd26;
        return d[4:0];
    endfunction

    function automatic logic [4:0] inc26(input logic [4:0] a);
        return (a == 5'd25) ? 5'd0 : a + 5'd1;
    endfunction

    function automatic logic [4:0] wiring(input tbl_e sel, input logic [4:0] idx);
        case (sel)
            TBL_I_F:   return ROT_I_F[idx];
            TBL_II_F:  return ROT_II_F[idx];
            TBL_III_F: return ROT_III_F[idx];
            TBL_I_B:   return ROT_I_B[idx];
            TBL_II_B:  return ROT_II_B[idx];
            TBL_III_B: return ROT_III_B[idx];
            default:   return 5'd0;
        endcase
    endfunction

    function automatic logic [4:0] rotor_pass(input tbl_e sel, input logic [4:0] c, input logic [4:0] p);
        return sub26(wiring(sel, add26(c, p)), p);
    endfunction

    logic [4:0] pos_l_q, pos_m_q, pos_r_q;
    logic [4:0] pos_l_d, pos_m_d, pos_r_d;
    logic [4:0] base_l, base_m, base_r;
    logic [4:0] step_l, step_m, step_r;
    logic       load_ok, sym_ok, err_d, err_q;

    logic       vld_p1_q;
    logic [4:0] c_p1_q, pl_p1_q, pm_p1_q, pr_p1_q;

    logic [4:0] e_r, e_m, e_l, e_ref, e_li, e_mi, e_ri;
    logic [6:0] encod_d, encod_q;
    logic       encod_val_q;

    always_comb begin
        load_ok = load_i && (pos_l_i <= 5'd25) && (pos_m_i <= 5'd25) && (pos_r_i <= 5'd25);
        sym_ok  = symb_val_i && (symb_i != 7'd0) && (symb_i <= 7'd26);
        err_d   = (symb_val_i && !sym_ok) || (load_i && !load_ok);

        // A coinciding load takes effect first; the symbol then steps from the loaded positions.
        base_l = load_ok ? pos_l_i : pos_l_q;
        base_m = load_ok ? pos_m_i : pos_m_q;
        base_r = load_ok ? pos_r_i : pos_r_q;

        step_r = inc26(base_r);
        step_m = ((base_r == NOTCH_R) || (base_m == NOTCH_M)) ? inc26(base_m) : base_m;
        step_l = (base_m == NOTCH_M) ? inc26(base_l) : base_l;

        pos_l_d = sym_ok ? step_l : base_l;
        pos_m_d = sym_ok ? step_m : base_m;
        pos_r_d = sym_ok ? step_r : base_r;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pos_l_q <= INIT_L_C;
            pos_m_q <= INIT_M_C;
            pos_r_q <= INIT_R_C;
            err_q   <= 1'b0;
        end else begin
            pos_l_q <= pos_l_d;
            pos_m_q <= pos_m_d;
            pos_r_q <= pos_r_d;
            err_q   <= err_d;
        end
    end

    // ---- stage 1: accepted letter and its stepped positions ----
    always_ff @(posedge clk_i) begin
        if (rst_i) vld_p1_q <= 1'b0;
        else       vld_p1_q <= sym_ok;
    end

    always_ff @(posedge clk_i) begin
        if (sym_ok) begin
            c_p1_q  <= symb_i[4:0] - 5'd1;
            pl_p1_q <= step_l;
            pm_p1_q <= step_m;
            pr_p1_q <= step_r;
        end
    end

    always_comb begin
        e_r     = rotor_pass(TBL_III_F, c_p1_q, pr_p1_q);
        e_m     = rotor_pass(TBL_II_F,  e_r,    pm_p1_q);
        e_l     = rotor_pass(TBL_I_F,   e_m,    pl_p1_q);
        e_ref   = REFL_B[e_l];
        e_li    = rotor_pass(TBL_I_B,   e_ref,  pl_p1_q);
        e_mi    = rotor_pass(TBL_II_B,  e_li,   pm_p1_q);
        e_ri    = rotor_pass(TBL_III_B, e_mi,   pr_p1_q);
        encod_d = vld_p1_q ? {2'b00, e_ri + 5'd1} : 7'd0;
    end

    // ---- stage 2: encoded letter output ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            encod_q     <= 7'd0;
            encod_val_q <= 1'b0;
        end else begin
            encod_q     <= encod_d;
            encod_val_q <= vld_p1_q;
        end
    end

    assign encod_o     = encod_q;
    assign encod_val_o = encod_val_q;
    assign err_o       = err_q;
    assign pos_l_o     = pos_l_q;
    assign pos_m_o     = pos_m_q;
    assign pos_r_o     = pos_r_q;

endmodule

// File: tb/tb_enigma_core.sv
// Scoreboard bench for enigma_core: a string-based Enigma model predicts each letter,
// and a negedge monitor matches DUT outputs (value and arrival cycle) against the queue.
module tb_enigma_core;

    logic       clk = 1'b0;
    logic       rst_i, symb_val_i, load_i;
    logic [6:0] symb_i;
    logic [4:0] pos_l_i, pos_m_i, pos_r_i;
    logic [6:0] encod_o;
    logic       encod_val_o, err_o;
    logic [4:0] pos_l_o, pos_m_o, pos_r_o;

    always #5 clk = ~clk;

    enigma_core #(.INIT_L(0), .INIT_M(0), .INIT_R(0)) dut (
        .clk_i(clk), .rst_i(rst_i), .symb_i(symb_i), .symb_val_i(symb_val_i),
        .load_i(load_i), .pos_l_i(pos_l_i), .pos_m_i(pos_m_i), .pos_r_i(pos_r_i),
        .encod_o(encod_o), .encod_val_o(encod_val_o), .err_o(err_o),
        .pos_l_o(pos_l_o), .pos_m_o(pos_m_o), .pos_r_o(pos_r_o)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int exp_sym;
        int in_sym;
        int due;
    } exp_t;
    exp_t sbq[$];

    string W_I   = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    string W_II  = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    string W_III = "BDFHJLCPRTXVZNYEIWGAKMOUSQ";
    string W_REF = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

    int ml = 0, mm = 0, mr = 0;

    function automatic int fwd(input string w, input int c, input int p);
        return (int'(w[(c + p) % 26]) - 65 - p + 26) % 26;
    endfunction

    function automatic int bwd(input string w, input int c, input int p);
        int t;
        t = (c + p) % 26;
        for (int j = 0; j < 26; j++)
            if (int'(w[j]) - 65 == t) return (j - p + 26) % 26;
        return -1;
    endfunction

    function automatic int model_encode(input int letter, input int l, input int m, input int r);
        int c;
        c = letter - 1;
        c = fwd(W_III, c, r);
        c = fwd(W_II, c, m);
        c = fwd(W_I, c, l);
        c = int'(W_REF[c]) - 65;
        c = bwd(W_I, c, l);
        c = bwd(W_II, c, m);
        c = bwd(W_III, c, r);
        return c + 1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Drive one cycle of stimulus at a negedge, advance the model, then check err/positions.
    task automatic apply(input bit sv, input int s, input bit ld, input int pl, input int pm,
                         input int pr, input int exp_ovr, input bit push);
        bit   bad_ld, bad_s, rn, mn;
        exp_t e;
        symb_val_i = sv;
        symb_i     = s[6:0];
        load_i     = ld;
        pos_l_i    = pl[4:0];
        pos_m_i    = pm[4:0];
        pos_r_i    = pr[4:0];
        bad_ld = ld && (pl > 25 || pm > 25 || pr > 25);
        bad_s  = sv && (s < 1 || s > 26);
        if (ld && !bad_ld) begin
            ml = pl; mm = pm; mr = pr;
        end
        if (sv && !bad_s) begin
            rn = (mr == 21);
            mn = (mm == 4);
            mr = (mr + 1) % 26;
            if (rn || mn) mm = (mm + 1) % 26;
            if (mn) ml = (ml + 1) % 26;
            if (push) begin
                e.exp_sym = (exp_ovr > 0) ? exp_ovr : model_encode(s, ml, mm, mr);
                e.in_sym  = s;
                e.due     = cyc + 2;
                sbq.push_back(e);
            end
        end
        @(negedge clk);
        check("err", int'(err_o), int'(bad_ld || bad_s));
        check("pos_l", int'(pos_l_o), ml);
        check("pos_m", int'(pos_m_o), mm);
        check("pos_r", int'(pos_r_o), mr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0, 0, -1, 1);
    endtask

    task automatic do_reset();
        symb_val_i = 1'b0;
        load_i     = 1'b0;
        rst_i      = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        ml = 0; mm = 0; mr = 0;
        check("rst_pos_l", int'(pos_l_o), 0);
        check("rst_pos_m", int'(pos_m_o), 0);
        check("rst_pos_r", int'(pos_r_o), 0);
        check("rst_val", int'(encod_val_o), 0);
    endtask

    task automatic check_pos(input string name, input int l, input int m, input int r);
        check({name, "_l"}, int'(pos_l_o), l);
        check({name, "_m"}, int'(pos_m_o), m);
        check({name, "_r"}, int'(pos_r_o), r);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0 && sbq[0].due < cyc) begin
            e = sbq.pop_front();
            n_checks++;
            $display("FAIL missed_output: no encod_val_o by cycle %0d, expected symbol %0d", e.due, e.exp_sym);
        end
        if (encod_val_o) begin
            n_checks++;
            if (sbq.size() == 0) begin
                $display("FAIL unexpected_output: got %0d with nothing expected (cycle %0d)", encod_o, cyc);
            end else begin
                e = sbq.pop_front();
                if (int'(encod_o) == e.exp_sym && cyc == e.due && int'(encod_o) != e.in_sym)
                    n_pass++;
                else
                    $display("FAIL encod: got %0d at cycle %0d expected %0d at cycle %0d (input %0d)",
                             encod_o, cyc, e.exp_sym, e.due, e.in_sym);
            end
        end else if (!rst_i) begin
            check("encod_idle_zero", int'(encod_o), 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp5[5];
        int dstep[9];
        int s;
        bit sv, ld;
        int pl, pm, pr;

        rst_i = 1'b1; symb_val_i = 1'b0; symb_i = '0; load_i = 1'b0;
        pos_l_i = '0; pos_m_i = '0; pos_r_i = '0;
        repeat (2) @(negedge clk);
        check("reset_encod", int'(encod_o), 0);
        check("reset_val", int'(encod_val_o), 0);
        check("reset_err", int'(err_o), 0);
        check_pos("reset_pos", 0, 0, 0);
        rst_i = 1'b0;

        exp5 = '{2, 4, 26, 7, 15};
        for (int i = 0; i < 5; i++) apply(1, 1, 0, 0, 0, 0, exp5[i], 1);
        check_pos("aaaaa_pos", 0, 0, 5);
        idle(3);

        do_reset();
        for (int i = 0; i < 5; i++) apply(1, exp5[i], 0, 0, 0, 0, 1, 1);
        idle(3);

        apply(0, 0, 1, 0, 3, 20, -1, 1);
        check_pos("load_adu", 0, 3, 20);
        dstep = '{0, 3, 21, 0, 4, 22, 1, 5, 23};
        for (int i = 0; i < 3; i++) begin
            apply(1, $urandom_range(1, 26), 0, 0, 0, 0, -1, 1);
            check_pos("dblstep", dstep[3*i], dstep[3*i+1], dstep[3*i+2]);
        end

        apply(0, 0, 1, 25, 25, 25, -1, 1);
        apply(1, $urandom_range(1, 26), 0, 0, 0, 0, -1, 1);
        check_pos("wrap_zzz", 25, 25, 0);
        apply(1, $urandom_range(1, 26), 1, 25, 4, 21, -1, 1);
        check_pos("wrap_zev", 0, 5, 22);
        idle(2);

        apply(1, 0, 0, 0, 0, 0, -1, 1);
        idle(1);
        apply(1, 27, 0, 0, 0, 0, -1, 1);
        idle(1);
        apply(0, 0, 1, 3, 26, 3, -1, 1);
        check_pos("bad_load", 0, 5, 22);
        apply(1, 31, 1, 30, 0, 0, -1, 1);
        idle(3);

        apply(1, 1, 0, 0, 0, 0, -1, 1);
        apply(1, 1, 0, 0, 0, 0, -1, 0);
        do_reset();
        apply(1, 1, 0, 0, 0, 0, 2, 1);
        idle(3);

        for (int i = 0; i < 400; i++) begin
            sv = ($urandom_range(0, 3) != 0);
            s  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(1, 26);
            ld = ($urandom_range(0, 11) == 0);
            pl = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 25);
            pm = ($urandom_range(0, 3) == 0) ? 4 : $urandom_range(0, 25);
            pr = ($urandom_range(0, 3) == 0) ? $urandom_range(19, 22) : $urandom_range(0, 25);
            apply(sv, s, ld, pl, pm, pr, -1, 1);
        end

        idle(4);
        check("scoreboard_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
